// File: rtl/cpu_debug_ocimem_ctrl_if.sv
// Bundles the JTAG-side strobes/monitor returns and the CPU Avalon-MM slave signals.
// No latency of its own; pure wiring between debug slave, CPU fabric and controller.
// Backpressure is carried by avs_waitrequest only; JTAG strobes are never stalled.
interface cpu_debug_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  // Requester side: debug slave plus CPU fabric.
  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
  );

  // Controller side.
  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/cpu_debug_ocimem_ctrl.sv
// Debug on-chip RAM shared between JTAG monitor (priority) and a CPU Avalon-MM slave.
// Latency: JTAG write 1 clk / read 2 clk after strobe; CPU write 0 waits, CPU read 1 wait.
// Backpressure: CPU stalled via avs_waitrequest while JTAG work pends; excess JTAG strobes dropped and flagged.
module cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  cpu_debug_ocimem_ctrl_if.slave bus
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JCAP = 2'd1,
    CRD  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Monitor registers and the one-deep JTAG pending slot.
  logic [ADDR_W-1:0] mon_addr;
  logic [31:0]       mon_data;
  logic              mon_ready;
  logic              mon_error;
  logic              jpend;
  logic              jop_wr;
  logic [31:0]       jdata;

  // Strobe decode results.
  logic sel_a;
  logic sel_b;
  logic sel_n;
  logic multi;
  logic a_rd;
  logic q_wr;
  logic q_rd;
  logic busy_drop;
  logic err_set;
  logic err_clr;
  logic rdy_clr;

  // FSM / RAM control.
  logic              ram_we;
  logic              ram_re;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic              jdone;
  logic              mon_load;
  logic [31:0]       mon_load_val;

  logic [31:0] mem [DEPTH];

  // Bits of jdo that carry nothing for this block.
  logic unused_jdo;
  assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[1:0]};

  // Resolve simultaneous strobes (b > a > no_action) and decide what gets queued or dropped.
  always_comb begin
    sel_b     = bus.take_action_ocimem_b;
    sel_a     = bus.take_action_ocimem_a & ~bus.take_action_ocimem_b;
    sel_n     = bus.take_no_action_ocimem_a & ~bus.take_action_ocimem_a & ~bus.take_action_ocimem_b;
    multi     = (bus.take_action_ocimem_a & bus.take_action_ocimem_b) |
                (bus.take_action_ocimem_a & bus.take_no_action_ocimem_a) |
                (bus.take_action_ocimem_b & bus.take_no_action_ocimem_a);
    a_rd      = sel_a & bus.jdo[34];
    q_wr      = sel_b & ~jpend;
    q_rd      = (a_rd | sel_n) & ~jpend;
    // The address part of ocimem_a is always taken; only the queued access can be refused.
    busy_drop = jpend & (sel_b | a_rd | sel_n);
    err_set   = multi | busy_drop;
    err_clr   = sel_a & bus.jdo[35];
    rdy_clr   = sel_a | q_wr | q_rd;
  end

  // Next state and RAM port steering; a pending JTAG op always beats the CPU.
  always_comb begin
    state_nxt    = state;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_be       = 4'h0;
    ram_addr     = mon_addr;
    ram_wdata    = jdata;
    jdone        = 1'b0;
    mon_load     = 1'b0;
    mon_load_val = jdata;
    case (state)
      IDLE: begin
        if (jpend) begin
          if (jop_wr) begin
            ram_we   = 1'b1;
            ram_be   = 4'hF;
            jdone    = 1'b1;
            mon_load = 1'b1;
          end else begin
            ram_re    = 1'b1;
            state_nxt = JCAP;
          end
        end else if (bus.avs_write) begin
          ram_we    = 1'b1;
          ram_be    = bus.avs_byteenable;
          ram_addr  = bus.avs_address;
          ram_wdata = bus.avs_writedata;
        end else if (bus.avs_read) begin
          ram_re    = 1'b1;
          ram_addr  = bus.avs_address;
          state_nxt = CRD;
        end
      end
      JCAP: begin
        jdone        = 1'b1;
        mon_load     = 1'b1;
        mon_load_val = ram_q;
        state_nxt    = IDLE;
      end
      CRD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset mid-access simply returns to IDLE with nothing written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Single-port RAM with byte enables and a registered read port; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) begin
          mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
    if (ram_re) begin
      ram_q <= mem[ram_addr];
    end
  end

  // Pending slot: set by an accepted strobe, cleared when the FSM retires the op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jpend  <= 1'b0;
      jop_wr <= 1'b0;
      jdata  <= 32'h0;
    end else begin
      if (jdone) begin
        jpend <= 1'b0;
      end
      if (q_wr | q_rd) begin
        jpend  <= 1'b1;
        jop_wr <= q_wr;
        jdata  <= bus.jdo[34:3];
      end
    end
  end

  // Monitor address: post-increment after each JTAG access; an explicit load overrides.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_addr <= '0;
    end else begin
      if (jdone) begin
        mon_addr <= mon_addr + ADDR_ONE;
      end
      if (sel_a) begin
        mon_addr <= bus.jdo[ADDR_W+1:2];
      end
    end
  end

  // Monitor data/ready/error; a new accepted strobe clears ready, error set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_data  <= 32'h0;
      mon_ready <= 1'b0;
      mon_error <= 1'b0;
    end else begin
      if (mon_load) begin
        mon_data  <= mon_load_val;
        mon_ready <= 1'b1;
      end
      if (rdy_clr) begin
        mon_ready <= 1'b0;
      end
      if (err_clr) begin
        mon_error <= 1'b0;
      end
      if (err_set) begin
        mon_error <= 1'b1;
      end
    end
  end

  assign bus.avs_readdata    = (state == CRD) ? ram_q : 32'h0;
  assign bus.avs_waitrequest = (bus.avs_read | bus.avs_write) &
                               ~((state == IDLE) & ~jpend & bus.avs_write) &
                               ~(state == CRD);
  assign bus.MonDReg         = mon_data;
  assign bus.monitor_ready   = mon_ready;
  assign bus.monitor_error   = mon_error;

endmodule
